complex_divider: RTL and testbench

- Inverse of the team's shared-multiplier complex multiplier. Takes a 16-bit complex numerator (a multiplier product) and an 8-bit complex denominator, and recovers the 8-bit complex quotient.
- Used to undo a known complex gain (equalisation/de-rotation) on product-width data.
- Sequential and area-lean: one registered multiplier is time-shared across all products, and a bit-serial restoring divider produces both quotients in parallel.

---
 rtl/complex_divider.sv | 214 +++++++++++++++++++++
 tb/tb_complex_divider.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/complex_divider.sv
// complex_divider: (a+jb)/(c+jd) -> saturated W_Q-bit complex quotient.
// One registered multiplier is shared across the six partial products.
// A bit-serial restoring divider then yields both quotient magnitudes.
module complex_divider #(
  parameter int W_NUM = 16,
  parameter int W_DEN = 8,
  parameter int W_Q   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_valid_in,
  input  logic signed [W_NUM-1:0] Re_num,
  input  logic signed [W_NUM-1:0] Im_num,
  input  logic signed [W_DEN-1:0] Re_den,
  input  logic signed [W_DEN-1:0] Im_den,
  output logic                    ready_out,
  output logic signed [W_Q-1:0]   Re_out,
  output logic signed [W_Q-1:0]   Im_out,
  output logic                    data_valid_out,
  output logic                    div_by_zero,
  output logic                    sat_out,
  output logic                    overrun
);

  localparam int W_P   = W_NUM + W_DEN;      // raw product width
  localparam int W_N   = W_NUM + W_DEN + 1;  // nr/ni width, also divider steps
  localparam int W_D   = 2 * W_DEN;          // denominator |c|^2+|d|^2
  localparam int W_R   = W_D + 1;            // remainder incl. shifted-in bit
  localparam int W_CNT = $clog2(W_N + 1);

  localparam logic [W_CNT-1:0] MUL_LAST = W_CNT'(6);
  localparam logic [W_CNT-1:0] DIV_LAST = W_CNT'(W_N - 1);
  localparam logic [W_N-1:0]   POS_LIM  = W_N'((1 << (W_Q - 1)) - 1);
  localparam logic [W_N-1:0]   NEG_LIM  = W_N'(1 << (W_Q - 1));
  localparam logic [W_Q-1:0]   QMAX     = {1'b0, {(W_Q-1){1'b1}}};
  localparam logic [W_Q-1:0]   QMIN     = {1'b1, {(W_Q-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                   state_q;
  logic [W_CNT-1:0]         cnt_q;
  logic signed [W_NUM-1:0]  a_q, b_q;
  logic signed [W_DEN-1:0]  c_q, d_q;
  logic signed [W_P-1:0]    mul_q;
  logic signed [W_N-1:0]    nr_q, ni_q;
  logic [W_D-1:0]           den_q;
  logic                     dz_q, neg_re_q, neg_im_q;
  logic [W_N-1:0]           qre_q, qim_q;   // dividend in, quotient out
  logic [W_R-1:0]           rre_q, rim_q;   // partial remainders
  logic                     ready_q, valid_q, dzo_q, sat_q, ovr_q;
  logic signed [W_Q-1:0]    re_q, im_q;

  logic signed [W_NUM-1:0]  op_x;
  logic signed [W_DEN-1:0]  op_y;
  logic signed [W_P-1:0]    mul_d;
  logic [W_D-1:0]           den_d;
  logic [W_N-1:0]           nr_abs, ni_abs;
  logic [W_R-1:0]           sre, sim, rre_d, rim_d;
  logic                     bre, bim;
  logic [W_Q:0]             fre, fim;       // {clipped, value}

  // Clamp a magnitude with its sign to the W_Q-bit signed range.
  function automatic logic [W_Q:0] sat_fn(input logic [W_N-1:0] mag, input logic neg);
    logic [W_N-1:0] nmag;
    nmag = -mag;
    if (!neg) begin
      if (mag > POS_LIM) sat_fn = {1'b1, QMAX};
      else               sat_fn = {1'b0, mag[W_Q-1:0]};
    end else begin
      if (mag > NEG_LIM) sat_fn = {1'b1, QMIN};
      else               sat_fn = {1'b0, nmag[W_Q-1:0]};
    end
  endfunction

  // Multiplier operand schedule: ac, bd, bc, ad, cc, dd.
  always_comb begin
    op_x = a_q;
    op_y = c_q;
    case (cnt_q[2:0])
      3'd0: begin op_x = a_q; op_y = c_q; end
      3'd1: begin op_x = b_q; op_y = d_q; end
      3'd2: begin op_x = b_q; op_y = c_q; end
      3'd3: begin op_x = a_q; op_y = d_q; end
      3'd4: begin op_x = {{(W_NUM-W_DEN){c_q[W_DEN-1]}}, c_q}; op_y = c_q; end
      3'd5: begin op_x = {{(W_NUM-W_DEN){d_q[W_DEN-1]}}, d_q}; op_y = d_q; end
      default: begin op_x = a_q; op_y = c_q; end
    endcase
  end

  assign mul_d  = W_P'(op_x) * W_P'(op_y);
  assign den_d  = den_q + W_D'(mul_q);          // completes c*c + d*d
  assign nr_abs = nr_q[W_N-1] ? -nr_q : nr_q;
  assign ni_abs = ni_q[W_N-1] ? -ni_q : ni_q;

  // One restoring-division step per component, MSB of dividend first.
  assign sre   = {rre_q[W_R-2:0], qre_q[W_N-1]};
  assign sim   = {rim_q[W_R-2:0], qim_q[W_N-1]};
  assign bre   = (sre >= {1'b0, den_q});
  assign bim   = (sim >= {1'b0, den_q});
  assign rre_d = bre ? sre - {1'b0, den_q} : sre;
  assign rim_d = bim ? sim - {1'b0, den_q} : sim;

  assign fre = sat_fn(qre_q, neg_re_q);
  assign fim = sat_fn(qim_q, neg_im_q);

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      mul_q    <= '0;
      nr_q     <= '0;
      ni_q     <= '0;
      den_q    <= '0;
      dz_q     <= 1'b0;
      neg_re_q <= 1'b0;
      neg_im_q <= 1'b0;
      qre_q    <= '0;
      qim_q    <= '0;
      rre_q    <= '0;
      rim_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      dzo_q    <= 1'b0;
      sat_q    <= 1'b0;
      ovr_q    <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
    end else begin
      // flags live only for the data_valid_out cycle
      valid_q <= 1'b0;
      dzo_q   <= 1'b0;
      sat_q   <= 1'b0;
      ovr_q   <= data_valid_in && !ready_q;
      case (state_q)
        IDLE: begin
          if (data_valid_in) begin
            a_q     <= Re_num;
            b_q     <= Im_num;
            c_q     <= Re_den;
            d_q     <= Im_den;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= MUL;
          end
        end
        MUL: begin
          mul_q <= mul_d;
          cnt_q <= cnt_q + 1'b1;
          // accumulate the product issued on the previous edge
          case (cnt_q[2:0])
            3'd1: nr_q  <= W_N'(mul_q);
            3'd2: nr_q  <= nr_q + W_N'(mul_q);
            3'd3: ni_q  <= W_N'(mul_q);
            3'd4: ni_q  <= ni_q - W_N'(mul_q);
            3'd5: den_q <= W_D'(mul_q);
            default: ;
          endcase
          if (cnt_q == MUL_LAST) begin
            den_q    <= den_d;
            dz_q     <= (den_d == '0);
            qre_q    <= nr_abs;
            qim_q    <= ni_abs;
            neg_re_q <= nr_q[W_N-1];
            neg_im_q <= ni_q[W_N-1];
            rre_q    <= '0;
            rim_q    <= '0;
            cnt_q    <= '0;
            state_q  <= DIV;
          end
        end
        DIV: begin
          qre_q <= {qre_q[W_N-2:0], bre};
          qim_q <= {qim_q[W_N-2:0], bim};
          rre_q <= rre_d;
          rim_q <= rim_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == DIV_LAST) state_q <= DONE;
        end
        DONE: begin
          // zero denominator: divider ran but its result is discarded
          if (dz_q) begin
            re_q  <= '0;
            im_q  <= '0;
            dzo_q <= 1'b1;
            sat_q <= 1'b0;
          end else begin
            re_q  <= fre[W_Q-1:0];
            im_q  <= fim[W_Q-1:0];
            dzo_q <= 1'b0;
            sat_q <= fre[W_Q] | fim[W_Q];
          end
          valid_q <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_out      = ready_q;
  assign Re_out         = re_q;
  assign Im_out         = im_q;
  assign data_valid_out = valid_q;
  assign div_by_zero    = dzo_q;
  assign sat_out        = sat_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_complex_divider.sv
// Scoreboard bench for complex_divider: driver pushes model results,
// monitor pops and compares on every data_valid_out pulse.
module tb_complex_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_valid_in = 1'b0;
  logic signed [15:0] Re_num = '0, Im_num = '0;
  logic signed [7:0]  Re_den = '0, Im_den = '0;
  logic ready_out, data_valid_out, div_by_zero, sat_out, overrun;
  logic signed [7:0]  Re_out, Im_out;

  complex_divider dut (
    .clk(clk), .rst(rst), .data_valid_in(data_valid_in),
    .Re_num(Re_num), .Im_num(Im_num), .Re_den(Re_den), .Im_den(Im_den),
    .ready_out(ready_out), .Re_out(Re_out), .Im_out(Im_out),
    .data_valid_out(data_valid_out), .div_by_zero(div_by_zero),
    .sat_out(sat_out), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int dz;
    int sat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_ovr = 0;
  int ovr_seen = 0;
  int busy_end = 0;
  int last_cap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact complex division, truncate toward zero, then clamp.
  function automatic int clamp(input longint v, inout int s);
    if (v > 127)  begin s = 1; return 127;  end
    if (v < -128) begin s = 1; return -128; end
    return int'(v);
  endfunction

  function automatic exp_t model(input longint a, b, c, d, input int t);
    exp_t e;
    longint nr, ni, den;
    int s;
    s   = 0;
    nr  = a * c + b * d;
    ni  = b * c - a * d;
    den = c * c + d * d;
    e.cyc = t;
    if (den == 0) begin
      e.re = 0; e.im = 0; e.dz = 1; e.sat = 0;
    end else begin
      e.re  = clamp(nr / den, s);
      e.im  = clamp(ni / den, s);
      e.dz  = 0;
      e.sat = s;
    end
    return e;
  endfunction

  // Issue one operation at the first negedge that shows ready_out high.
  task automatic send(input int a, b, c, d);
    int t = 0;
    while (!ready_out && t < 200) begin @(negedge clk); t++; end
    if (!ready_out) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    Re_num = 16'(a); Im_num = 16'(b); Re_den = 8'(c); Im_den = 8'(d);
    data_valid_in = 1'b1;
    sb.push_back(model(a, b, c, d, cyc));
    last_cap = cyc;
    busy_end = cyc + 34;
    @(negedge clk);
    data_valid_in = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: compare every result pulse against the scoreboard head.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (overrun) ovr_seen++;
    if (data_valid_out) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("Re_out", Re_out, e.re);
        chk("Im_out", Im_out, e.im);
        chk("div_by_zero", div_by_zero, e.dz);
        chk("sat_out", sat_out, e.sat);
        chk("latency", cyc, e.cyc + 34);
        chk("ready_with_valid", ready_out, 1);
      end
    end else if (prev_valid) begin
      chk("flags_cleared", {div_by_zero, sat_out}, 0);
    end
    prev_valid = data_valid_out;
  end

  initial begin
    int first_cap, t;
    // reset state
    #12;
    chk("rst_ready", ready_out, 1);
    chk("rst_outs", {Re_out, Im_out, data_valid_out, div_by_zero, sat_out, overrun}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // nominal, truncation, saturation, extreme, divide by zero
    send(-5, 10, 1, 2);         drain();
    send(7, 0, 2, 0);           drain();
    send(-7, -7, 2, 0);         drain();
    send(1000, -1000, 1, 0);    drain();
    send(-32768, -32768, -128, -128); drain();
    send(100, 100, 0, 0);       drain();

    // busy: one dropped pulse, then an input held across the ready rise
    send(-5, 10, 1, 2);
    first_cap = last_cap;
    repeat (9) @(negedge clk);
    Re_num = 16'(500); Im_num = 16'(1); Re_den = 8'(3); Im_den = 8'(1);
    data_valid_in = 1'b1;
    if (cyc < busy_end) exp_ovr++;
    @(negedge clk);
    data_valid_in = 1'b0;
    chk("overrun_pulse", overrun, 1);
    @(negedge clk);
    chk("overrun_once", overrun, 0);
    Re_num = 16'(-300); Im_num = 16'(40); Re_den = 8'(-3); Im_den = 8'(2);
    data_valid_in = 1'b1;
    t = 0;
    while (!ready_out && t < 100) begin exp_ovr++; @(negedge clk); t++; end
    sb.push_back(model(-300, 40, -3, 2, cyc));
    chk("held_capture_gap", cyc - first_cap, 34);
    busy_end = cyc + 34;
    @(negedge clk);
    data_valid_in = 1'b0;
    drain();

    // reset in the middle of DIV aborts the operation
    send(-300, 40, -3, 2);
    while (cyc < last_cap + 20) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    sb.delete();
    busy_end = 0;
    chk("midrst_re_im", {Re_out, Im_out}, 0);
    chk("midrst_ready", ready_out, 1);
    chk("midrst_valid", data_valid_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(-5, 10, 1, 2);         drain();

    // randomized operations, some back-to-back
    for (int i = 0; i < 40; i++) begin
      int a, b, c, d, q1, q2;
      case ($urandom_range(0, 3))
        0: begin
          a = $urandom_range(0, 4000) - 2000; b = $urandom_range(0, 4000) - 2000;
          c = $urandom_range(0, 40) - 20;     d = $urandom_range(0, 40) - 20;
        end
        1: begin
          a = $urandom_range(0, 65535) - 32768; b = $urandom_range(0, 65535) - 32768;
          c = $urandom_range(0, 255) - 128;     d = $urandom_range(0, 255) - 128;
        end
        2: begin
          a = $urandom_range(0, 65535) - 32768; b = $urandom_range(0, 65535) - 32768;
          c = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 6) - 3;
          d = 0;
        end
        default: begin
          q1 = $urandom_range(0, 200) - 100; q2 = $urandom_range(0, 200) - 100;
          c  = $urandom_range(0, 200) - 100; d  = $urandom_range(0, 200) - 100;
          a  = q1 * c - q2 * d + $urandom_range(0, 10) - 5;
          b  = q1 * d + q2 * c + $urandom_range(0, 10) - 5;
        end
      endcase
      send(a, b, c, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    chk("overrun_count", ovr_seen, exp_ovr);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
